// File: rtl/dlzl_pkg.sv
// Shared definitions for the dlzl read-stream block: default widths, FSM state
// codes and the read-tag record carried through the RAM latency pipeline.
package dlzl_pkg;

  localparam int DEF_DATA_W     = 512;
  localparam int DEF_ADDR_W     = 15;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dlzl_sync_fifo.sv
// Single-clock FIFO used as the output buffer; caller guarantees no push when full.
// Read data is forced to zero while empty so the stream outputs are clean after reset.
module dlzl_sync_fifo
  import dlzl_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = fifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  pushData,
  input  logic          pop,
  output logic [W-1:0]  popData,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign doPush  = push && !clr;
  assign doPop   = pop && !empty && !clr;
  assign empty   = (count == '0);
  assign popData = empty ? '0 : mem[rdPtr];

  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dlzl_rd_stream.sv
// Streams len consecutive RAM words starting at base_addr onto a valid/ready port.
// Optional abort input is compiled in with `define DLZL_RD_ABORT_EN.
module dlzl_rd_stream
  import dlzl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DLZL_RD_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CW = fifo_cnt_w(FIFO_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] curAddr;
  logic [ADDR_W:0]   remaining;
  tag_t              tagPipe [RD_LAT];
  logic              doneReg;
  logic [CW-1:0]     fifoCount;
  logic              fifoEmpty;
  logic [DATA_W:0]   popWord;
  logic              issue;
  logic              lastIssue;
  logic              pop;
  logic              lastPop;
  logic              abortHit;
  int                inflight;

`ifdef DLZL_RD_ABORT_EN
  assign abortHit = abort && (state != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  // NOTE: combinational blocks use blocking assignments and set a default first so no latch is inferred.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + int'(tagPipe[i].vld);
  end

  // Credit check counts both buffered and in-flight words, so the FIFO can never overflow.
  assign issue     = (state == RUN) && (remaining != '0) && !abortHit
                     && ((int'(fifoCount) + inflight) < FIFO_DEPTH);
  assign lastIssue = issue && (remaining == (ADDR_W+1)'(1));
  assign pop       = !fifoEmpty && m_ready;
  assign lastPop   = pop && popWord[DATA_W];

  assign busy     = (state != IDLE);
  assign done     = doneReg || (lastPop && !abortHit);
  assign ram_en   = issue;
  assign ram_addr = curAddr;
  assign m_valid  = !fifoEmpty;
  assign m_data   = popWord[DATA_W-1:0];
  assign m_last   = popWord[DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      curAddr   <= '0;
      remaining <= '0;
      doneReg   <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tagPipe[i] <= '0;
    end else begin
      doneReg <= 1'b0;
      for (int i = RD_LAT - 1; i > 0; i--) tagPipe[i] <= tagPipe[i-1];
      tagPipe[0] <= '{vld: issue, last: lastIssue};
      if (issue) begin
        curAddr   <= curAddr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            curAddr   <= base_addr;
            remaining <= len;
            if (len == '0) doneReg <= 1'b1;
            else           state   <= RUN;
          end
        end
        RUN:     if (lastIssue) state <= DRAIN;
        DRAIN:   if (lastPop)   state <= IDLE;
        default: state <= IDLE;
      endcase
      if (abortHit) begin
        state     <= IDLE;
        doneReg   <= 1'b1;
        remaining <= '0;
        for (int i = 0; i < RD_LAT; i++) tagPipe[i] <= '0;
      end
    end
  end

  dlzl_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (abortHit),
    .push     (tagPipe[RD_LAT-1].vld),
    .pushData ({tagPipe[RD_LAT-1].last, ram_dout}),
    .pop      (pop),
    .popData  (popWord),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

endmodule

// File: tb/tb_dlzl_rd_stream.sv
// Self-checking bench for dlzl_rd_stream: table-driven jobs, random jobs and
// hand-written reset/abort sequences against a queue-based reference model.
module tb_dlzl_rd_stream;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 15;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
`ifdef DLZL_RD_ABORT_EN
  logic              abort;
`endif

  dlzl_rd_stream #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DLZL_RD_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {a ^ 15'h2A5C, 2'b10, a};
  endfunction

  // RAM model: data for the address presented with ram_en appears RD_LAT cycles later.
  logic [ADDR_W:0] ramPipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) ramPipe[i] = '0;
  always @(posedge clk) begin
    ramPipe[0] <= {ram_en, ram_addr};
    for (int i = 1; i < RD_LAT; i++) ramPipe[i] <= ramPipe[i-1];
  end
  assign ram_dout = ramPipe[RD_LAT-1][ADDR_W] ? word_of(ramPipe[RD_LAT-1][ADDR_W-1:0])
                                              : 32'hDEAD_BEEF;

  // Reference model: expected read addresses and expected beats of the current job.
  logic [ADDR_W-1:0] addrQ [$];
  logic [DATA_W:0]   expQ  [$];
  int                outstanding = 0;
  int                pops = 0;
  logic              prevStall = 1'b0;
  logic [DATA_W-1:0] prevData;
  logic              prevLast;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ram_en) begin
        if (addrQ.size() == 0) check("ram_en_unexpected", 64'd1, 64'd0);
        else begin
          check("ram_addr", 64'(ram_addr), 64'(addrQ.pop_front()));
          outstanding++;
          check("outstanding_le_depth", 64'(outstanding <= FIFO_DEPTH), 64'd1);
        end
      end
      if (prevStall && m_valid) begin
        check("stall_data_stable", 64'(m_data), 64'(prevData));
        check("stall_last_stable", 64'(m_last), 64'(prevLast));
      end
      if (m_valid && m_ready) begin
        pops++;
        if (expQ.size() == 0) check("beat_unexpected", 64'd1, 64'd0);
        else begin
          logic [DATA_W:0] e;
          e = expQ.pop_front();
          check("beat_data", 64'(m_data), 64'(e[DATA_W-1:0]));
          check("beat_last", 64'(m_last), 64'(e[DATA_W]));
        end
        outstanding--;
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end else begin
      prevStall = 1'b0;
    end
  end

  // m_ready pattern: 0 = held high, 1 = toggling, 2 = random.
  int readyMode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    int                mode;
    int                expDone;
  } vec_t;

  task automatic load_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(i);
      addrQ.push_back(a);
      expQ.push_back({(i == int'(n) - 1), word_of(a)});
    end
  endtask

  task automatic clear_model();
    addrQ.delete();
    expQ.delete();
    outstanding = 0;
  endtask

  task automatic run_job(input vec_t v);
    int firstV = -1;
    int doneC  = -1;
    int lastC  = -1;
    int p0;
    @(posedge clk);
    #1;
    readyMode = v.mode;
    start     = 1'b1;
    base_addr = v.base;
    len       = v.len;
    load_job(v.base, v.len);
    p0 = pops;
    for (int c = 1; c <= 400 && doneC < 0; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (c == 1) check("busy_cycle1", 64'(busy), 64'(v.len != 0));
      if (m_valid && firstV < 0) firstV = c;
      if (m_valid && m_ready && m_last) lastC = c;
      if (done) doneC = c;
    end
    check("done_seen", 64'(doneC > 0), 64'd1);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("beat_count", 64'(pops - p0), 64'(v.len));
    check("addr_queue_empty", 64'(addrQ.size()), 64'd0);
    if (v.len != 0) begin
      check("first_valid_cycle", 64'(firstV), 64'(1 + RD_LAT + 1));
      check("done_with_last", 64'(lastC), 64'(doneC));
    end
    if (v.expDone > 0) check("done_cycle", 64'(doneC), 64'(v.expDone));
    clear_model();
  endtask

  vec_t vecs [7];

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
`ifdef DLZL_RD_ABORT_EN
    abort     = 1'b0;
`endif
    vecs[0] = '{15'h0010, 16'd8,  0, 11};
    vecs[1] = '{15'h7FFE, 16'd4,  0, 7};
    vecs[2] = '{15'h0100, 16'd16, 1, 0};
    vecs[3] = '{15'h0000, 16'd0,  0, 1};
    vecs[4] = '{15'h7FF0, 16'd20, 2, 0};
    vecs[5] = '{15'h1234, 16'd1,  0, 4};
    vecs[6] = '{15'h0040, 16'd12, 0, 15};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_ram_en",  64'(ram_en),  64'd0);
    check("rst_ram_addr",64'(ram_addr),64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_job(vecs[i]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.base    = ADDR_W'($urandom);
      v.len     = (ADDR_W+1)'($urandom_range(1, 24));
      v.mode    = 2;
      v.expDone = 0;
      run_job(v);
    end

    // Reset at beat 3 of a 10-word job.
    begin
      int p0;
      int waited = 0;
      int lateValid = 0;
      @(posedge clk);
      #1;
      readyMode = 0;
      start = 1'b1; base_addr = 15'h0200; len = 16'd10;
      load_job(15'h0200, 16'd10);
      p0 = pops;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (pops - p0 < 3 && waited < 100) begin
        @(posedge clk);
        waited++;
      end
      check("reset_beat3_reached", 64'(pops - p0 >= 3), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_busy",    64'(busy),    64'd0);
      check("midrst_done",    64'(done),    64'd0);
      check("midrst_ram_en",  64'(ram_en),  64'd0);
      check("midrst_ram_addr",64'(ram_addr),64'd0);
      check("midrst_m_valid", 64'(m_valid), 64'd0);
      check("midrst_m_last",  64'(m_last),  64'd0);
      check("midrst_m_data",  64'(m_data),  64'd0);
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (m_valid) lateValid++;
      end
      check("no_valid_after_reset", 64'(lateValid), 64'd0);
      run_job(vecs[0]);
    end

`ifdef DLZL_RD_ABORT_EN
    // Abort at beat 5 of a 20-word job.
    begin
      int p0;
      int waited = 0;
      @(posedge clk);
      #1;
      readyMode = 0;
      start = 1'b1; base_addr = 15'h0300; len = 16'd20;
      load_job(15'h0300, 16'd20);
      p0 = pops;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (pops - p0 < 5 && waited < 100) begin
        @(posedge clk);
        waited++;
      end
      check("abort_beat5_reached", 64'(pops - p0 >= 5), 64'd1);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_m_valid", 64'(m_valid), 64'd0);
      check("abort_done",    64'(done),    64'd1);
      check("abort_busy",    64'(busy),    64'd0);
      clear_model();
      @(negedge clk);
      check("abort_done_pulse", 64'(done), 64'd0);
      run_job(vecs[1]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
